// File: rtl/capi_command_arbiter_pkg.sv
// Shared CAPI command-path types: arbiter state encoding, field widths and
// the opcode/address/size bundle carried from requester to PSL.
package capi_command_arbiter_pkg;

  localparam int OPCODE_W   = 13;
  localparam int SIZE_W     = 12;
  localparam int TAG_W      = 8;
  localparam int CODE_W     = 8;
  localparam int CMD_ADDR_W = 64;
  localparam int CREDIT_MAX = 255;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOAD  = 2'd1,
    ARB_RUN   = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [CMD_ADDR_W-1:0] address;
    logic [SIZE_W-1:0]     size;
  } capi_cmd_t;

endpackage

// File: rtl/capi_command_arbiter_if.sv
// Requester-side command/response bundle plus the PSL command/response ports.
interface capi_command_arbiter_if
  import capi_command_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int CREDIT_WIDTH = 9
) ();
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][OPCODE_W-1:0]   req_command;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_address;
  logic [NUM_REQ-1:0][SIZE_W-1:0]     req_size;

  logic                               cmd_valid;
  logic [OPCODE_W-1:0]                cmd_command;
  logic [TAG_W-1:0]                   cmd_tag;
  logic [ADDR_WIDTH-1:0]              cmd_address;
  logic [SIZE_W-1:0]                  cmd_size;

  logic                               rsp_valid;
  logic [TAG_W-1:0]                   rsp_tag;
  logic [CODE_W-1:0]                  rsp_code;
  logic [CREDIT_WIDTH-1:0]            rsp_credits;

  logic [NUM_REQ-1:0]                 rsp_out_valid;
  logic [TAG_W-1:0]                   rsp_out_tag;
  logic [CODE_W-1:0]                  rsp_out_code;

  // arbiter side
  modport master (
    input  req_valid, req_command, req_address, req_size,
    input  rsp_valid, rsp_tag, rsp_code, rsp_credits,
    output req_ready,
    output cmd_valid, cmd_command, cmd_tag, cmd_address, cmd_size,
    output rsp_out_valid, rsp_out_tag, rsp_out_code
  );

  // requesters + PSL
  modport slave (
    output req_valid, req_command, req_address, req_size,
    output rsp_valid, rsp_tag, rsp_code, rsp_credits,
    input  req_ready,
    input  cmd_valid, cmd_command, cmd_tag, cmd_address, cmd_size,
    input  rsp_out_valid, rsp_out_tag, rsp_out_code
  );
endinterface

// File: rtl/capi_command_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);
  int idx;

  // Walk the rotation backwards so the last hit is the one nearest ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant_idx = IDX_W'(idx);
        grant_any = 1'b1;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end
endmodule

// File: rtl/capi_command_arbiter.sv
// Shares the PSL command port among NUM_REQ requesters: round-robin issue,
// credit (croom) tracking, tag allocation and response routing by tag owner.
module capi_command_arbiter
  import capi_command_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_TAGS     = 16,
  parameter int ADDR_WIDTH   = 64,
  parameter int CREDIT_WIDTH = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enabled,
  input  logic [7:0]             room_init,
  capi_command_arbiter_if.master bus,
  output logic                   idle,
  output logic                   protocol_error
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TIW   = (MAX_TAGS > 1) ? $clog2(MAX_TAGS) : 1;

  localparam logic [1:0] S_IDLE  = ARB_IDLE;
  localparam logic [1:0] S_LOAD  = ARB_LOAD;
  localparam logic [1:0] S_RUN   = ARB_RUN;
  localparam logic [1:0] S_DRAIN = ARB_DRAIN;

  logic [1:0]                     state;
  logic [CREDIT_WIDTH-1:0]        credits;
  logic [MAX_TAGS-1:0]            busy;
  logic [MAX_TAGS-1:0][IDX_W-1:0] owner;
  logic [IDX_W-1:0]               rr_ptr;

  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_any;
  logic [TIW-1:0]          alloc_tag;
  logic                    tag_free;
  logic                    permit, accept;
  logic [TIW-1:0]          rsp_idx;
  logic                    rsp_hit, rsp_bad;
  int                      cred_sum;
  logic                    cred_err;
  logic [CREDIT_WIDTH-1:0] cred_next;
  capi_cmd_t               cmd_sel, cmd_q;
  logic [TAG_W-1:0]        cmd_tag_q;
  logic                    cmd_valid_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Lowest free tag from the pre-update table, so a tag freed this cycle
  // can never be handed out in the same cycle.
  always_comb begin
    alloc_tag = '0;
    tag_free  = 1'b0;
    for (int t = MAX_TAGS - 1; t >= 0; t--)
      if (!busy[t]) begin
        alloc_tag = TIW'(t);
        tag_free  = 1'b1;
      end
  end

  assign permit        = (state == S_RUN) && (credits != '0) && tag_free;
  assign accept        = permit && grant_any;
  assign bus.req_ready = permit ? grant : '0;

  assign rsp_idx = bus.rsp_tag[TIW-1:0];
  assign rsp_hit = bus.rsp_valid && (int'(bus.rsp_tag) < MAX_TAGS) && busy[rsp_idx];
  assign rsp_bad = bus.rsp_valid && !rsp_hit;

  // Issue and credit return fold into one update, then saturate to 0..255.
  always_comb begin
    cred_sum = int'(credits) - (accept ? 1 : 0)
             + (bus.rsp_valid ? int'($signed(bus.rsp_credits)) : 0);
    cred_err  = (cred_sum > CREDIT_MAX) || (cred_sum < 0);
    cred_next = (cred_sum > CREDIT_MAX) ? CREDIT_WIDTH'(CREDIT_MAX) :
                (cred_sum < 0)          ? '0 : CREDIT_WIDTH'(cred_sum);
  end

  always_comb begin
    cmd_sel.opcode  = bus.req_command[grant_idx];
    cmd_sel.address = CMD_ADDR_W'(bus.req_address[grant_idx]);
    cmd_sel.size    = bus.req_size[grant_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      credits        <= '0;
      busy           <= '0;
      owner          <= '0;
      rr_ptr         <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_q          <= '0;
      cmd_tag_q      <= '0;
      bus.rsp_out_valid <= '0;
      bus.rsp_out_tag   <= '0;
      bus.rsp_out_code  <= '0;
      protocol_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (enabled) state <= S_LOAD;
        S_LOAD:  state <= S_RUN;
        S_RUN:   if (!enabled) state <= S_DRAIN;
        S_DRAIN: if (!(|busy)) state <= S_IDLE;
                 else if (enabled) state <= S_RUN;
        default: state <= S_IDLE;
      endcase

      credits <= (state == S_LOAD) ? CREDIT_WIDTH'(room_init) : cred_next;
      protocol_error <= protocol_error | rsp_bad | (cred_err && state != S_LOAD);

      if (accept) begin
        busy[alloc_tag]  <= 1'b1;
        owner[alloc_tag] <= grant_idx;
        rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        cmd_q     <= cmd_sel;
        cmd_tag_q <= TAG_W'(alloc_tag);
      end
      if (rsp_hit) begin
        busy[rsp_idx]    <= 1'b0;
        bus.rsp_out_tag  <= bus.rsp_tag;
        bus.rsp_out_code <= bus.rsp_code;
      end
      cmd_valid_q       <= accept;
      bus.rsp_out_valid <= rsp_hit ? (NUM_REQ'(1) << owner[rsp_idx]) : '0;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_command = cmd_q.opcode;
  assign bus.cmd_address = cmd_q.address[ADDR_WIDTH-1:0];
  assign bus.cmd_size    = cmd_q.size;
  assign bus.cmd_tag     = cmd_tag_q;

  assign idle = (state == S_IDLE) && !(|busy);
endmodule

// File: tb/tb_capi_command_arbiter.sv
// Directed bench for capi_command_arbiter: issue order, tags, credits,
// invalid responses, drain and asynchronous reset.
module tb_capi_command_arbiter;
  import capi_command_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int MT = 16;
  localparam int AW = 64;
  localparam int CW = 9;

  logic       clock = 1'b0;
  logic       reset;
  logic       enabled;
  logic [7:0] room_init;
  logic       idle;
  logic       protocol_error;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base;

  capi_command_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .CREDIT_WIDTH(CW)) bus ();

  capi_command_arbiter #(.NUM_REQ(NR), .MAX_TAGS(MT), .ADDR_WIDTH(AW), .CREDIT_WIDTH(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .enabled        (enabled),
    .room_init      (room_init),
    .bus            (bus),
    .idle           (idle),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.cmd_valid === 1'b1) pulses++;

  function automatic logic [12:0] opc(input int k);
    return 13'(13'h100 + k);
  endfunction
  function automatic logic [63:0] adr(input int k);
    return 64'hA000_0000_0000_0000 + 64'(k) * 64'h1000;
  endfunction
  function automatic logic [11:0] sz(input int k);
    return 12'(128 + k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic rsp(input int tag, input int cr, input int code);
    bus.rsp_valid   = 1'b1;
    bus.rsp_tag     = 8'(tag);
    bus.rsp_credits = 9'(cr);
    bus.rsp_code    = 8'(code);
    step();
    bus.rsp_valid   = 1'b0;
  endtask

  task automatic do_reset;
    reset         = 1'b1;
    enabled       = 1'b0;
    bus.req_valid = '0;
    bus.rsp_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    room_init       = 8'd4;
    bus.rsp_tag     = '0;
    bus.rsp_code    = '0;
    bus.rsp_credits = '0;
    for (int k = 0; k < NR; k++) begin
      bus.req_command[k] = opc(k);
      bus.req_address[k] = adr(k);
      bus.req_size[k]    = sz(k);
    end
    do_reset();

    chk("reset_idle", 64'(idle), 1);
    chk("reset_cmd_valid", 64'(bus.cmd_valid), 0);
    chk("reset_ready", 64'(bus.req_ready), 0);
    chk("reset_perr", 64'(protocol_error), 0);
    chk("reset_rsp_out", 64'(bus.rsp_out_valid), 0);
    chk("reset_cmd_tag", 64'(bus.cmd_tag), 0);

    // four requesters, four credits
    bus.req_valid = 4'hF;
    enabled = 1'b1;
    #1;
    chk("idle_no_ready", 64'(bus.req_ready), 0);
    base = pulses;
    step();
    chk("load_no_ready", 64'(bus.req_ready), 0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_ready_%0d", k), 64'(bus.req_ready), 64'(1 << k));
      step();
      chk($sformatf("rr_cmd_valid_%0d", k), 64'(bus.cmd_valid), 1);
      chk($sformatf("rr_tag_%0d", k), 64'(bus.cmd_tag), 64'(k));
      chk($sformatf("rr_opc_%0d", k), 64'(bus.cmd_command), 64'(opc(k)));
    end
    chk("rr_addr_3", bus.cmd_address, adr(3));
    chk("rr_size_3", 64'(bus.cmd_size), 64'(sz(3)));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("nocredit_ready_%0d", k), 64'(bus.req_ready), 0);
      step();
    end
    chk("pulse_count", 64'(pulses - base), 4);

    // response to tag 2 returns a credit; requester 0 reuses tag 2
    rsp(2, 1, 0);
    chk("rsp2_out_valid", 64'(bus.rsp_out_valid), 64'h4);
    chk("rsp2_out_tag", 64'(bus.rsp_out_tag), 2);
    chk("rsp2_out_code", 64'(bus.rsp_out_code), 0);
    chk("rsp2_ready", 64'(bus.req_ready), 64'h1);
    step();
    chk("reuse_tag", 64'(bus.cmd_tag), 2);
    chk("reuse_opc", 64'(bus.cmd_command), 64'(opc(0)));
    chk("rsp_out_one_cycle", 64'(bus.rsp_out_valid), 0);

    // accept and response in the same cycle at credits=1
    rsp(3, 1, 8'h11);
    chk("rsp3_out_valid", 64'(bus.rsp_out_valid), 64'h8);
    chk("rsp3_ready", 64'(bus.req_ready), 64'h2);
    rsp(0, 1, 8'h22);
    chk("same_cycle_tag", 64'(bus.cmd_tag), 3);
    chk("same_cycle_opc", 64'(bus.cmd_command), 64'(opc(1)));
    chk("same_cycle_rsp_out", 64'(bus.rsp_out_valid), 64'h1);
    chk("same_cycle_code", 64'(bus.rsp_out_code), 64'h22);
    chk("same_cycle_credit_kept", 64'(bus.req_ready), 64'h4);
    step();
    chk("freed_tag_next", 64'(bus.cmd_tag), 0);
    chk("freed_tag_opc", 64'(bus.cmd_command), 64'(opc(2)));

    // invalid tags and credit underflow
    bus.req_valid = '0;
    rsp(9, 2, 0);
    chk("bad_tag_no_out", 64'(bus.rsp_out_valid), 0);
    chk("bad_tag_perr", 64'(protocol_error), 1);
    rsp(15, -5, 0);
    bus.req_valid = 4'h1;
    #1;
    chk("underflow_sat_zero", 64'(bus.req_ready), 0);
    chk("perr_sticky", 64'(protocol_error), 1);
    bus.req_valid = '0;
    rsp(20, 1, 0);
    chk("oor_tag_no_out", 64'(bus.rsp_out_valid), 0);
    bus.req_valid = 4'h1;
    #1;
    chk("credit_from_zero", 64'(bus.req_ready), 64'h1);
    step();
    chk("next_free_tag", 64'(bus.cmd_tag), 4);
    bus.req_valid = '0;

    // tag exhaustion with a single requester
    do_reset();
    chk("reset2_perr", 64'(protocol_error), 0);
    chk("reset2_idle", 64'(idle), 1);
    room_init = 8'd64;
    enabled = 1'b1;
    bus.req_valid = 4'h1;
    step();
    step();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("tags_ready_%0d", k), 64'(bus.req_ready), 64'h1);
      step();
      chk($sformatf("tags_tag_%0d", k), 64'(bus.cmd_tag), 64'(k));
    end
    chk("tags_full_ready", 64'(bus.req_ready), 0);
    step();
    chk("tags_full_ready2", 64'(bus.req_ready), 0);
    chk("tags_full_no_cmd", 64'(bus.cmd_valid), 0);
    rsp(5, 0, 8'h33);
    chk("tags_rsp_out", 64'(bus.rsp_out_valid), 64'h1);
    chk("tags_freed_ready", 64'(bus.req_ready), 64'h1);
    step();
    chk("tags_reuse5", 64'(bus.cmd_tag), 5);
    bus.req_valid = '0;

    // drain with three outstanding
    do_reset();
    room_init = 8'd8;
    enabled = 1'b1;
    bus.req_valid = 4'h7;
    step();
    step();
    step();
    step();
    step();
    chk("drain_setup_tag", 64'(bus.cmd_tag), 2);
    bus.req_valid = '0;
    enabled = 1'b0;
    step();
    bus.req_valid = 4'hF;
    #1;
    chk("drain_no_ready", 64'(bus.req_ready), 0);
    chk("drain_not_idle", 64'(idle), 0);
    step();
    chk("drain_no_cmd", 64'(bus.cmd_valid), 0);
    bus.req_valid = '0;
    rsp(0, 1, 0);
    rsp(1, 1, 0);
    rsp(2, 1, 8'h44);
    chk("drain_last_out", 64'(bus.rsp_out_valid), 64'h4);
    chk("drain_still_busy", 64'(idle), 0);
    step();
    chk("drain_idle", 64'(idle), 1);

    // asynchronous reset in the middle of a burst
    enabled = 1'b1;
    bus.req_valid = 4'hF;
    step();
    step();
    step();
    chk("burst_tag0", 64'(bus.cmd_tag), 0);
    step();
    chk("burst_valid", 64'(bus.cmd_valid), 1);
    chk("burst_tag1", 64'(bus.cmd_tag), 1);
    reset = 1'b1;
    #1;
    chk("async_cmd_valid", 64'(bus.cmd_valid), 0);
    chk("async_idle", 64'(idle), 1);
    chk("async_ready", 64'(bus.req_ready), 0);
    reset = 1'b0;
    enabled = 1'b0;
    bus.req_valid = '0;
    rsp(0, 0, 0);
    chk("abandoned_no_out", 64'(bus.rsp_out_valid), 0);
    chk("abandoned_perr", 64'(protocol_error), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
